// File: rtl/updown_counter_arbiter.sv
// Round-robin arbiter that owns the up/down inputs of a shared counter and issues one step per cycle.
// Define SAT_EN to stop a move at the counter limits instead of letting the counter wrap.
module updown_counter_arbiter #(
    parameter int N_REQ   = 4,
    parameter int COUNT_W = 3,
    parameter int STEP_W  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          dir,
    input  logic [N_REQ*STEP_W-1:0]   steps,
    output logic [N_REQ-1:0]          grant,
    output logic [N_REQ-1:0]          done,
    output logic                      busy,
    output logic                      cnt_up,
    output logic                      cnt_down,
    input  logic [COUNT_W-1:0]        cnt_value,
    output logic                      sat_hit
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_r, state_n;
    logic [IDX_W-1:0]   owner_r, owner_n;
    logic [IDX_W-1:0]   rr_r, rr_n;
    logic [STEP_W-1:0]  remaining_r, remaining_n;
    logic               dir_r, dir_n;
    logic [N_REQ-1:0]   grant_r, grant_n;
    logic [N_REQ-1:0]   done_r, done_n;
    logic               busy_r, busy_n;
    logic               up_r, up_n;
    logic               down_r, down_n;
    logic               sat_r, sat_n;

    logic               pick_found_s;
    logic [IDX_W-1:0]   pick_idx_s;
    logic               owner_req_s;
    logic               owner_dir_s;
    logic [STEP_W-1:0]  owner_steps_s;
    logic               at_limit_s;
    logic               grant_limit_s;

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = {N_REQ{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [IDX_W-1:0] next_rr(input logic [IDX_W-1:0] idx);
        if (idx == IDX_W'(N_REQ - 1)) begin
            return {IDX_W{1'b0}};
        end else begin
            return idx + IDX_W'(1);
        end
    endfunction

    // Round-robin search: first requester at or after the pointer, wrapping.
    always_comb begin
        int idx_v;
        pick_found_s = 1'b0;
        pick_idx_s   = {IDX_W{1'b0}};
        idx_v        = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx_v = (int'(rr_r) + k) % N_REQ;
            if (!pick_found_s && req[idx_v]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = IDX_W'(idx_v);
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    assign owner_req_s   = req[owner_r];
    assign owner_dir_s   = dir[owner_r];
    assign owner_steps_s = steps[int'(owner_r)*STEP_W +: STEP_W];

`ifdef SAT_EN
    logic [COUNT_W-1:0] projected_s;

    // Counter value after any pulse already on the wire lands.
    always_comb begin
        if (up_r) begin
            projected_s = cnt_value + COUNT_W'(1);
        end else if (down_r) begin
            projected_s = cnt_value - COUNT_W'(1);
        end else begin
            projected_s = cnt_value;
        end
        at_limit_s    = dir_r ? (projected_s == {COUNT_W{1'b1}}) : (projected_s == {COUNT_W{1'b0}});
        grant_limit_s = owner_dir_s ? (cnt_value == {COUNT_W{1'b1}}) : (cnt_value == {COUNT_W{1'b0}});
    end
`else
    logic cnt_value_unused_s;
    assign cnt_value_unused_s = ^cnt_value;
    assign at_limit_s         = 1'b0;
    assign grant_limit_s      = 1'b0;
`endif

    // Next-state and next-output logic; every output is registered from these.
    always_comb begin
        state_n     = state_r;
        owner_n     = owner_r;
        rr_n        = rr_r;
        remaining_n = remaining_r;
        dir_n       = dir_r;
        grant_n     = grant_r;
        done_n      = {N_REQ{1'b0}};
        up_n        = 1'b0;
        down_n      = 1'b0;
        sat_n       = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (pick_found_s) begin
                    state_n = S_GRANT;
                    owner_n = pick_idx_s;
                    grant_n = onehot(pick_idx_s);
                end else begin
                    grant_n = {N_REQ{1'b0}};
                end
            end
            S_GRANT: begin
                if (!owner_req_s) begin
                    state_n = S_IDLE;
                    grant_n = {N_REQ{1'b0}};
                    rr_n    = next_rr(owner_r);
                end else if (owner_steps_s == {STEP_W{1'b0}}) begin
                    state_n     = S_DONE;
                    dir_n       = owner_dir_s;
                    remaining_n = {STEP_W{1'b0}};
                    done_n      = grant_r;
                end else if (grant_limit_s) begin
                    state_n     = S_DONE;
                    dir_n       = owner_dir_s;
                    remaining_n = {STEP_W{1'b0}};
                    done_n      = grant_r;
                    sat_n       = 1'b1;
                end else begin
                    // remaining counts the pulses still to issue after this first one
                    state_n     = S_RUN;
                    dir_n       = owner_dir_s;
                    remaining_n = owner_steps_s - STEP_W'(1);
                    up_n        = owner_dir_s;
                    down_n      = !owner_dir_s;
                end
            end
            S_RUN: begin
                if (!owner_req_s) begin
                    state_n     = S_IDLE;
                    grant_n     = {N_REQ{1'b0}};
                    rr_n        = next_rr(owner_r);
                    remaining_n = {STEP_W{1'b0}};
                end else if (remaining_r == {STEP_W{1'b0}}) begin
                    state_n = S_DONE;
                    done_n  = grant_r;
                end else if (at_limit_s) begin
                    state_n     = S_DONE;
                    remaining_n = {STEP_W{1'b0}};
                    done_n      = grant_r;
                    sat_n       = 1'b1;
                end else begin
                    remaining_n = remaining_r - STEP_W'(1);
                    up_n        = dir_r;
                    down_n      = !dir_r;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
                grant_n = {N_REQ{1'b0}};
                rr_n    = next_rr(owner_r);
            end
            default: begin
                state_n = S_IDLE;
                grant_n = {N_REQ{1'b0}};
            end
        endcase
        busy_n = (state_n != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= S_IDLE;
            owner_r     <= {IDX_W{1'b0}};
            rr_r        <= {IDX_W{1'b0}};
            remaining_r <= {STEP_W{1'b0}};
            dir_r       <= 1'b0;
            grant_r     <= {N_REQ{1'b0}};
            done_r      <= {N_REQ{1'b0}};
            busy_r      <= 1'b0;
            up_r        <= 1'b0;
            down_r      <= 1'b0;
            sat_r       <= 1'b0;
        end else begin
            state_r     <= state_n;
            owner_r     <= owner_n;
            rr_r        <= rr_n;
            remaining_r <= remaining_n;
            dir_r       <= dir_n;
            grant_r     <= grant_n;
            done_r      <= done_n;
            busy_r      <= busy_n;
            up_r        <= up_n;
            down_r      <= down_n;
            sat_r       <= sat_n;
        end
    end

    assign grant    = grant_r;
    assign done     = done_r;
    assign busy     = busy_r;
    assign cnt_up   = up_r;
    assign cnt_down = down_r;
    assign sat_hit  = sat_r;

endmodule

// File: doc/updown_counter_arbiter.md
Name: updown_counter_arbiter

Overview:
Shares one 3-bit up/down counter (clk/reset/up/down/count interface) between N_REQ requesters. Each requester asks for a signed move: direction plus step count. The block grants round-robin and drives the counter's up/down inputs with one step per cycle. It pulses done to the owner on completion. Sits directly in front of the counter; no requester touches the counter's up/down inputs directly.

Parameters:
N_REQ, 4, number of requesters (2..8)
COUNT_W, 3, width of counter value fed back
STEP_W, 4, width of per-request step count (0..2^STEP_W-1 steps)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
req  in  N_REQ  request per requester; level, held until done[i]
dir  in  N_REQ  per-requester direction, 1=up 0=down; sampled at grant
steps  in  N_REQ*STEP_W  per-requester step count, requester i at [i*STEP_W +: STEP_W]; sampled at grant
grant  out  N_REQ  one-hot owner, high GRANT through DONE
done  out  N_REQ  one-cycle completion pulse to owner
busy  out  1  high whenever state != IDLE
cnt_up  out  1  to counter up input, registered
cnt_down  out  1  to counter down input, registered
cnt_value  in  COUNT_W  counter count output
sat_hit  out  1  one-cycle pulse with done when move stopped at limit (SAT_EN only; else tied 0)

Behaviour:
- Reset (reset=0, async): state=IDLE, grant=0, done=0, busy=0, cnt_up=0, cnt_down=0, sat_hit=0, rr pointer=0, remaining=0.
- FSM: IDLE, GRANT, RUN, DONE.
- IDLE: if any req, pick first requester i at or after rr pointer (wrapping) -> GRANT; grant[i] set same edge.
- GRANT (1 cycle): latch dir[i], steps[i] into remaining. remaining==0 -> DONE (no pulses). Else -> RUN; first cnt_up/cnt_down high in first RUN cycle.
- RUN: exactly one of cnt_up/cnt_down high each cycle (never both). remaining decrements per pulse. Last pulse cycle -> DONE. N steps = N consecutive pulse cycles.
- DONE (1 cycle): done[i]=1, cnt_up=cnt_down=0, rr pointer=(i+1) mod N_REQ -> IDLE; grant cleared on exit.
- Latency: req high in IDLE cycle t -> grant at t+1 -> first pulse t+2 -> done at t+2+N.
- Re-arbitration: min 1 IDLE cycle between grants; requester holding req after done re-arbitrates at lowest priority.
- Abort: req[owner] sampled low in GRANT or RUN -> pulses stop next cycle; IDLE directly, no done; rr pointer still advances.
- Counter wraps natively (7+1=0, 0-1=7); without SAT_EN the arbiter does not prevent wrap.
- Non-owner req/dir/steps changes ignored while busy.

Optional Feature:
SAT_EN defined: RUN computes projected = cnt_value +1/-1 if a pulse is in flight this cycle, else cnt_value. Next pulse would pass 2^COUNT_W-1 (up) or 0 (down) -> no further pulse; -> DONE; sat_hit pulses with done; remaining discarded. A move starting at the limit emits zero pulses.
SAT_EN undefined: no limit check; sat_hit constant 0; all requested steps issued, wrap allowed.

Test Plan:
- Reset release, req[0]=1, dir=1, steps=3, counter at 0 -> grant[0] next cycle, 3 cnt_up pulses, done[0] 1 cycle, count=3.
- req[0] and req[2] high same cycle (both steps=2 up) after reset -> grant[0] first, then grant[2] after one IDLE cycle; count=4; rr pointer=3.
- steps=0 request -> GRANT then DONE, no cnt_up/cnt_down, done pulse, count unchanged.
- No SAT_EN: count=6, up steps=3 -> count 7,0,1; done, sat_hit=0. SAT_EN: same -> 1 pulse, count=7, done with sat_hit=1.
- Owner drops req after 2 of 5 down steps from 5 -> count=3, no done, other pending requester granted next.
- Assert reset mid-RUN -> outputs 0 immediately, state IDLE; after release, req[1] wins (pointer=0 but req[0] low).
